// File: rtl/fifo_stream_adapter.sv
`default_nettype none
// ============================================================================
// Module   : fifo_stream_adapter
// Brief    : Turns a show-ahead FIFO read port into a registered valid/ready
//            stream through a two-entry (main + skid) output buffer.
// Revision : 1.0 - initial release
// ============================================================================
module fifo_stream_adapter #(
    parameter int WIDTH = 10
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [WIDTH-1:0] fifo_data_i,
    input  logic             fifo_empty_i,
    output logic             fifo_rd_en_o,
    output logic             m_valid_o,
    input  logic             m_ready_i,
    output logic [WIDTH-1:0] m_data_o,
    output logic [1:0]       level_o
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_e;

    state_e           r_state_q;
    state_e           w_state_d;
    logic [WIDTH-1:0] r_main_q;
    logic [WIDTH-1:0] w_main_d;
    logic [WIDTH-1:0] r_skid_q;
    logic [WIDTH-1:0] w_skid_d;
    logic             w_pop;
    logic             w_take;

    // Pop depends only on occupancy and FIFO status, never on m_ready_i.
    assign w_pop  = rst_ni && !fifo_empty_i && (r_state_q != ST_TWO);
    assign w_take = m_valid_o && m_ready_i;

    assign fifo_rd_en_o = w_pop;
    assign m_valid_o    = (r_state_q != ST_EMPTY);
    assign m_data_o     = r_main_q;
    assign level_o      = r_state_q;

    always_comb begin
        w_state_d = r_state_q;
        w_main_d  = r_main_q;
        w_skid_d  = r_skid_q;
        case (r_state_q)
            ST_ONE: begin
                if (w_pop && w_take) begin
                    w_main_d = fifo_data_i;
                end else if (w_pop) begin
                    w_skid_d  = fifo_data_i;
                    w_state_d = ST_TWO;
                end else if (w_take) begin
                    w_state_d = ST_EMPTY;
                end
            end
            ST_TWO: begin
                if (w_take) begin
                    w_main_d  = r_skid_q;
                    w_state_d = ST_ONE;
                end
            end
            default: begin
                // EMPTY, and the unused encoding 3 recovers as EMPTY
                if (w_pop) begin
                    w_main_d  = fifo_data_i;
                    w_state_d = ST_ONE;
                end else begin
                    w_state_d = ST_EMPTY;
                end
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state_q <= ST_EMPTY;
            r_main_q  <= '0;
            r_skid_q  <= '0;
        end else begin
            r_state_q <= w_state_d;
            r_main_q  <= w_main_d;
            r_skid_q  <= w_skid_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fifo_stream_adapter.sv
`default_nettype none
// ============================================================================
// Module   : tb_fifo_stream_adapter
// Brief    : Bench for fifo_stream_adapter with a show-ahead FIFO model and a
//            queue-based reference of stream order and buffer occupancy.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fifo_stream_adapter;

    localparam int W = 10;

    logic          clk = 1'b0;
    logic          rst_ni;
    logic          fifo_rst_n;
    logic          wr_en;
    logic [W-1:0]  wr_data;
    logic          m_ready;
    logic [W-1:0]  fifo_data;
    logic          fifo_empty;
    logic          fifo_rd_en;
    logic          m_valid;
    logic [W-1:0]  m_data;
    logic [1:0]    level;

    logic [W-1:0]  mem [4096];
    logic [11:0]   wr_ptr;
    logic [11:0]   rd_ptr;

    logic [W-1:0]  sb [$];
    int            fifo_cnt_m;
    int            lvl_m;
    bit            exp_pop;
    bit            exp_take;
    int            n_pass;
    int            n_total;

    always #5 clk = ~clk;

    fifo_stream_adapter #(.WIDTH(W)) dut (
        .clk_i        (clk),
        .rst_ni       (rst_ni),
        .fifo_data_i  (fifo_data),
        .fifo_empty_i (fifo_empty),
        .fifo_rd_en_o (fifo_rd_en),
        .m_valid_o    (m_valid),
        .m_ready_i    (m_ready),
        .m_data_o     (m_data),
        .level_o      (level)
    );

    // Show-ahead FIFO: head word visible whenever not empty
    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_data  = mem[rd_ptr];

    always @(posedge clk or negedge fifo_rst_n) begin
        if (!fifo_rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_en) begin
                mem[wr_ptr] <= wr_data;
                wr_ptr      <= wr_ptr + 12'd1;
            end
            if (fifo_rd_en) rd_ptr <= rd_ptr + 12'd1;
        end
    end

    task automatic model_clear();
        sb.delete();
        fifo_cnt_m = 0;
        lvl_m      = 0;
    endtask

    // Apply inputs just after the falling edge and derive expected strobes.
    task automatic drive(input bit wr, input logic [W-1:0] d, input bit rdy);
        wr_en   = wr;
        wr_data = d;
        m_ready = rdy;
        #1;
        exp_pop  = rst_ni && (fifo_cnt_m > 0) && (lvl_m < 2);
        exp_take = rst_ni && (lvl_m > 0) && rdy;
    endtask

    task automatic advance();
        @(posedge clk);
        if (fifo_rst_n && wr_en) begin
            sb.push_back(wr_data);
            fifo_cnt_m++;
        end
        if (rst_ni) begin
            if (exp_take) sb.delete(0);
            fifo_cnt_m -= int'(exp_pop);
            lvl_m      += int'(exp_pop) - int'(exp_take);
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        fifo_rst_n = 1'b1;
        drive(1'b1, 10'h3A5, 1'b0); advance();
        drive(1'b1, 10'h15A, 1'b0); advance();
        drive(1'b0, 10'h000, 1'b1);
        n_total++; if (fifo_rd_en !== 1'b0) $display("FAIL reset_rd_en: got %b want 0", fifo_rd_en); else n_pass++;
        n_total++; if (m_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", m_valid); else n_pass++;
        n_total++; if (level !== 2'd0) $display("FAIL reset_level: got %0d want 0", level); else n_pass++;
        n_total++; if (m_data !== '0) $display("FAIL reset_data: got %h want 000", m_data); else n_pass++;
        advance();
        rst_ni = 1'b1;
        drive(1'b0, 10'h000, 1'b0);
        n_total++; if (fifo_rd_en !== 1'b1) $display("FAIL release_rd_en: got %b want 1", fifo_rd_en); else n_pass++;
        advance();
        drive(1'b0, 10'h000, 1'b0);
        n_total++; if (m_valid !== 1'b1 || m_data !== 10'h3A5)
            $display("FAIL release_first_beat: got v=%b d=%h want v=1 d=3a5", m_valid, m_data); else n_pass++;
        advance();
        for (int c = 0; c < 8; c++) begin
            drive(1'b0, 10'h000, 1'b1);
            if (lvl_m != 0) begin
                n_total++; if (m_data !== sb[0]) $display("FAIL reset_drain_data: got %h want %h", m_data, sb[0]); else n_pass++;
            end
            advance();
        end
        n_total++; if (m_valid !== 1'b0 || sb.size() != 0)
            $display("FAIL reset_drain_done: got v=%b left=%0d want v=0 left=0", m_valid, sb.size()); else n_pass++;
    endtask

    task automatic test_streaming();
        int  k = 0;
        bit  gap = 1'b0;
        for (int c = 0; c < 12; c++) begin
            drive(c < 8, W'(c + 1), 1'b1);
            n_total++; if (fifo_rd_en !== exp_pop) $display("FAIL stream_rd_en: cycle %0d got %b want %b", c, fifo_rd_en, exp_pop); else n_pass++;
            if (m_valid === 1'b1) begin
                if (k >= 8) begin
                    n_total++; $display("FAIL stream_extra_beat: got beat %0d want 8 beats", k + 1);
                end else begin
                    n_total++; if (m_data !== W'(k + 1)) $display("FAIL stream_data: got %h want %h", m_data, W'(k + 1)); else n_pass++;
                    n_total++; if (level !== 2'd1) $display("FAIL stream_level: got %0d want 1", level); else n_pass++;
                end
                k++;
            end else if (k > 0 && k < 8) begin
                gap = 1'b1;
            end
            advance();
        end
        n_total++; if (k != 8 || gap) $display("FAIL stream_count: got %0d beats gap=%b want 8 beats gap=0", k, gap); else n_pass++;
    endtask

    task automatic test_backpressure();
        logic [W-1:0] v [4];
        for (int i = 0; i < 4; i++) v[i] = W'($urandom_range(0, 1023));
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, v[i], 1'b0);
            advance();
        end
        for (int c = 0; c < 4; c++) begin
            drive(1'b0, 10'h000, 1'b0);
            n_total++; if (level !== 2'd2) $display("FAIL bp_level: got %0d want 2", level); else n_pass++;
            n_total++; if (fifo_rd_en !== 1'b0) $display("FAIL bp_rd_en: got %b want 0", fifo_rd_en); else n_pass++;
            n_total++; if (m_valid !== 1'b1 || m_data !== v[0])
                $display("FAIL bp_hold: got v=%b d=%h want v=1 d=%h", m_valid, m_data, v[0]); else n_pass++;
            n_total++; if (12'(wr_ptr - rd_ptr) !== 12'd2) $display("FAIL bp_fifo_cnt: got %0d want 2", 12'(wr_ptr - rd_ptr)); else n_pass++;
            advance();
        end
        for (int k = 0; k < 4; k++) begin
            drive(1'b0, 10'h000, 1'b1);
            n_total++; if (m_valid !== 1'b1 || m_data !== v[k])
                $display("FAIL bp_release: beat %0d got v=%b d=%h want v=1 d=%h", k, m_valid, m_data, v[k]); else n_pass++;
            advance();
        end
        drive(1'b0, 10'h000, 1'b0);
        n_total++; if (m_valid !== 1'b0) $display("FAIL bp_done: got v=%b want 0", m_valid); else n_pass++;
    endtask

    task automatic test_random();
        int           n_written = 0;
        bit           prev_stall = 1'b0;
        logic [W-1:0] prev_data = '0;
        for (int cyc = 0; cyc < 20000 && (n_written < 1000 || sb.size() > 0); cyc++) begin
            bit wr = (n_written < 1000) && ($urandom_range(0, 99) < 60);
            drive(wr, W'($urandom_range(0, 1023)), 1'($urandom_range(0, 1)));
            if (wr) n_written++;
            n_total++; if (fifo_rd_en !== exp_pop) $display("FAIL rand_rd_en: cycle %0d got %b want %b", cyc, fifo_rd_en, exp_pop); else n_pass++;
            n_total++; if (fifo_rd_en === 1'b1 && fifo_empty === 1'b1) $display("FAIL rand_pop_empty: cycle %0d got pop=1 want 0", cyc); else n_pass++;
            n_total++; if (level !== 2'(lvl_m)) $display("FAIL rand_level: cycle %0d got %0d want %0d", cyc, level, lvl_m); else n_pass++;
            n_total++; if (m_valid !== (lvl_m != 0)) $display("FAIL rand_valid: cycle %0d got %b want %b", cyc, m_valid, lvl_m != 0); else n_pass++;
            if (lvl_m != 0) begin
                n_total++; if (m_data !== sb[0]) $display("FAIL rand_data: cycle %0d got %h want %h", cyc, m_data, sb[0]); else n_pass++;
            end
            if (prev_stall) begin
                n_total++; if (m_valid !== 1'b1 || m_data !== prev_data)
                    $display("FAIL rand_stall_stable: cycle %0d got v=%b d=%h want v=1 d=%h", cyc, m_valid, m_data, prev_data); else n_pass++;
            end
            prev_stall = m_valid && !m_ready;
            prev_data  = m_data;
            advance();
        end
        n_total++; if (sb.size() != 0 || n_written != 1000)
            $display("FAIL rand_complete: got left=%0d written=%0d want left=0 written=1000", sb.size(), n_written); else n_pass++;
    endtask

    task automatic test_mid_reset();
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, W'($urandom_range(0, 1023)), 1'b0);
            advance();
        end
        wr_en = 1'b0;
        n_total++; if (level !== 2'd2) $display("FAIL midrst_pre_level: got %0d want 2", level); else n_pass++;
        #2;
        rst_ni     = 1'b0;
        fifo_rst_n = 1'b0;
        #1;
        n_total++; if (m_valid !== 1'b0) $display("FAIL midrst_valid: got %b want 0", m_valid); else n_pass++;
        n_total++; if (level !== 2'd0) $display("FAIL midrst_level: got %0d want 0", level); else n_pass++;
        n_total++; if (m_data !== '0) $display("FAIL midrst_data: got %h want 000", m_data); else n_pass++;
        n_total++; if (fifo_rd_en !== 1'b0) $display("FAIL midrst_rd_en: got %b want 0", fifo_rd_en); else n_pass++;
        model_clear();
        @(negedge clk);
        rst_ni     = 1'b1;
        fifo_rst_n = 1'b1;
        for (int c = 0; c < 10; c++) begin
            drive(c < 6, W'(10'h200 + c), 1'b1);
            n_total++; if (fifo_rd_en !== exp_pop) $display("FAIL midrst_resume_rd_en: got %b want %b", fifo_rd_en, exp_pop); else n_pass++;
            if (lvl_m != 0) begin
                n_total++; if (m_data !== sb[0]) $display("FAIL midrst_resume_data: got %h want %h", m_data, sb[0]); else n_pass++;
            end
            advance();
        end
        n_total++; if (sb.size() != 0) $display("FAIL midrst_resume_done: got left=%0d want 0", sb.size()); else n_pass++;
    endtask

    task automatic test_single();
        logic [W-1:0] x = W'($urandom_range(0, 1023));
        drive(1'b1, x, 1'b0); advance();
        drive(1'b0, 10'h000, 1'b0);
        n_total++; if (fifo_rd_en !== 1'b1) $display("FAIL single_pop: got %b want 1", fifo_rd_en); else n_pass++;
        advance();
        drive(1'b0, 10'h000, 1'b1);
        n_total++; if (m_valid !== 1'b1 || m_data !== x)
            $display("FAIL single_beat: got v=%b d=%h want v=1 d=%h", m_valid, m_data, x); else n_pass++;
        advance();
        for (int c = 0; c < 3; c++) begin
            drive(1'b0, 10'h000, c[0]);
            n_total++; if (m_valid !== 1'b0 || level !== 2'd0 || fifo_rd_en !== 1'b0)
                $display("FAIL single_after: got v=%b l=%0d p=%b want v=0 l=0 p=0", m_valid, level, fifo_rd_en); else n_pass++;
            advance();
        end
    endtask

    initial begin
        n_pass     = 0;
        n_total    = 0;
        rst_ni     = 1'b0;
        fifo_rst_n = 1'b0;
        wr_en      = 1'b0;
        wr_data    = '0;
        m_ready    = 1'b0;
        model_clear();
        test_reset();
        test_streaming();
        test_backpressure();
        test_random();
        test_mid_reset();
        test_single();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
